instr_fetch_unit: RTL
=====================

// Module: instr_fetch_unit
// PURPOSE
//  Requester side of the instruction-memory interface. Holds the PC, drives a word
//  address into the combinational-read instruction memory, and captures returned words
//  with their PC into a prefetch FIFO. Presents them to decode over a valid/ready
//  handshake. Accepts redirects (branch/jump) from execute, flushing stale entries.
// PARAMETERS
//  RESET_PC    32'h0000_0000  PC loaded on reset; bits [1:0] must be 0
//  FIFO_DEPTH  4              prefetch entries; power of two, 2..16
// PORTS
//  clk             input   1   rising-edge clock
//  rst             input   1   asynchronous active-high reset
//  fetch_en        input   1   1 = fetch allowed; 0 = stop issuing (IDLE)
//  imem_addr       output  32  byte address to instruction memory (= pc register)
//  imem_rdata      input   32  instruction word for imem_addr, same cycle
//  if_valid        output  1   FIFO head holds a valid instruction
//  if_ready        input   1   decode accepts head this cycle
//  if_instr        output  32  head instruction
//  if_pc           output  32  head PC
//  redirect_valid  input   1   flush and restart fetch at redirect_pc
//  redirect_pc     input   32  new PC; bits [1:0] forced to 0
//  perf_fetched    output  32  words pushed (FETCH_PERF_EN only, else 0)
//  perf_flushes    output  32  redirects taken (FETCH_PERF_EN only, else 0)
// BEHAVIOUR
//  Reset (async, any time, incl. mid-fetch): pc=RESET_PC, state=IDLE, FIFO empty,
//   if_valid=0, if_instr=0, if_pc=0, perf counters=0, imem_addr=RESET_PC.
//  FSM: IDLE -> FETCH when fetch_en=1 (sampled at clk edge); FETCH -> IDLE when
//   fetch_en=0. IDLE: no push, pc holds, FIFO still drains to decode.
//  Pop: if_valid && if_ready at clk edge removes head. if_valid = (count != 0).
//   if_instr/if_pc come from head storage (registered), zero when empty.
//  Push (FETCH, no redirect): when count<FIFO_DEPTH, or count==FIFO_DEPTH with a pop
//   in the same cycle: store {pc, imem_rdata}, pc <= pc+4. Otherwise pc holds
//   (imem_addr stable while full).
//  Latency: first word at RESET_PC visible on if_valid one cycle after FSM enters FETCH.
//   Steady state: 1 instruction/cycle with if_ready held high.
//  Simultaneous push+pop: count unchanged, both take effect.
//  Redirect (highest priority, any state): FIFO cleared, pop and push suppressed that
//   cycle, pc <= {redirect_pc[31:2],2'b00}; if_valid=0 next cycle; first new word
//   visible the cycle after that (if in FETCH). In IDLE only pc updates.
//  Wrap-around: pc+4 wraps modulo 2^32 (32'hFFFF_FFFC -> 32'h0); FIFO pointers wrap
//   modulo FIFO_DEPTH; count is $clog2(FIFO_DEPTH)+1 bits, never exceeds FIFO_DEPTH.
//  fetch_en dropping while full: no loss, entries drain, pc points to next unfetched.
// CONFIGURATION
//  FETCH_PERF_EN defined: perf_fetched +1 per push, perf_flushes +1 per redirect
//   cycle; both wrap at 2^32, cleared by rst only.
//  FETCH_PERF_EN undefined: counters not built; perf_fetched/perf_flushes tied to 0.
//  Fetch behaviour identical either way.
// TESTING
//  T1 reset: rst=1 mid-run -> if_valid=0, imem_addr=RESET_PC, perf counters 0.
//  T2 stream: fetch_en=1, if_ready=1, mem[0..3]=0x00100093,0x00200113,0x00300193,
//     0x00400213 -> if_pc 0,4,8,12 on consecutive cycles, instr in order, no gaps.
//  T3 backpressure: if_ready=0 for 10 cycles, FIFO_DEPTH=4 -> 4 entries held,
//     imem_addr stuck at 0x10; release -> PCs 0,4,8,12,16 with no drop/duplicate.
//  T4 redirect: redirect_valid with redirect_pc=0x3E while 3 entries queued ->
//     next cycle if_valid=0, then if_pc=0x3C; old entries never appear.
//  T5 redirect+pop same cycle while full: pop ignored, FIFO empty after, pc=target.
//  T6 wrap: redirect to 0xFFFF_FFFC -> if_pc 0xFFFF_FFFC then 0x0000_0000; with
//     FETCH_PERF_EN after T2..T6 perf_flushes equals redirect count driven.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: PC sequencing, prefetch FIFO, decode handshake, redirect flush.
// Optional performance counters are built only when FETCH_PERF_EN is defined.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch_en,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_flushes
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_FETCH = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [31:0]        pc_q, pc_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [31:0]        instr_mem_q [FIFO_DEPTH];
  logic [31:0]        pc_mem_q    [FIFO_DEPTH];

  logic fifo_full;
  logic do_pop;
  logic do_push;

  // Redirect outranks both pop and push so no stale entry can leak out in the flush cycle.
  always_comb begin
    fifo_full = (count_q == DEPTH_C);
    do_pop    = (count_q != '0) && if_ready && !redirect_valid;
    do_push   = (state_q == ST_FETCH) && !redirect_valid && (!fifo_full || do_pop);
  end

  always_comb begin
    state_d  = fetch_en ? ST_FETCH : ST_IDLE;
    pc_d     = pc_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (redirect_valid) begin
      pc_d     = {redirect_pc[31:2], 2'b00};
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        pc_d     = pc_q + 32'd4;
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      pc_q     <= RESET_PC;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        instr_mem_q[i] <= '0;
        pc_mem_q[i]    <= '0;
      end
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (do_push) begin
        instr_mem_q[wr_ptr_q] <= imem_rdata;
        pc_mem_q[wr_ptr_q]    <= pc_q;
      end
    end
  end

  always_comb begin
    imem_addr = pc_q;
    if_valid  = (count_q != '0);
    if_instr  = if_valid ? instr_mem_q[rd_ptr_q] : 32'd0;
    if_pc     = if_valid ? pc_mem_q[rd_ptr_q] : 32'd0;
  end

`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched_q, perf_fetched_d;
  logic [31:0] perf_flushes_q, perf_flushes_d;

  always_comb begin
    perf_fetched_d = do_push ? perf_fetched_q + 32'd1 : perf_fetched_q;
    perf_flushes_d = redirect_valid ? perf_flushes_q + 32'd1 : perf_flushes_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_fetched_q <= '0;
      perf_flushes_q <= '0;
    end else begin
      perf_fetched_q <= perf_fetched_d;
      perf_flushes_q <= perf_flushes_d;
    end
  end

  assign perf_fetched = perf_fetched_q;
  assign perf_flushes = perf_flushes_q;
`else
  assign perf_fetched = 32'd0;
  assign perf_flushes = 32'd0;
`endif

endmodule
